// File: rtl/muldiv_sequencer_if.sv
// Request/result bus between the EXE stage and the multiply/divide sequencer.
interface muldiv_sequencer_if;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] A;
  logic [31:0] B;
  logic        HILO_READ;
  logic        FLUSH;
  logic        BUSY;
  logic        STALL;
  logic        DONE;
  logic        HILO_WE;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;

  modport master (
    output START, OP, A, B, HILO_READ, FLUSH,
    input  BUSY, STALL, DONE, HILO_WE, HI_OUT, LO_OUT
  );

  modport slave (
    input  START, OP, A, B, HILO_READ, FLUSH,
    output BUSY, STALL, DONE, HILO_WE, HI_OUT, LO_OUT
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// cycle over 32 cycles, with sign handling before and after the loop.
module muldiv_sequencer (
  input logic               CLK,
  input logic               RESET,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, FIN} state_t;

  state_t      state, state_next;
  logic [5:0]  count;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        sign_a, sign_b;
  logic [31:0] opnd;      // multiplicand (multiply) or divisor (divide) magnitude
  logic [63:0] work;      // {acc, multiplier} or {remainder, dividend/quotient}
  logic [31:0] hi_q, lo_q;

  logic        accept, busy, done;
  logic        is_div, is_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_trial, div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] hi_res, lo_res;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign accept    = (state == IDLE || state == FIN) && bus.START && !bus.FLUSH;

  // Next-state and handshake outputs of the sequencer FSM.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (bus.START) state_next = PREP;
      PREP: begin
        busy       = 1'b1;
        state_next = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (count == 6'd31) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = bus.START ? PREP : IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides everything, including a START seen this cycle.
    if (bus.FLUSH) state_next = IDLE;
  end

  assign bus.BUSY    = busy;
  assign bus.STALL   = busy & (bus.START | bus.HILO_READ);
  assign bus.DONE    = done;
  assign bus.HILO_WE = done;
  assign bus.HI_OUT  = hi_q;
  assign bus.LO_OUT  = lo_q;

  // One iteration step plus the final sign correction and result placement.
  always_comb begin
    abs_a     = (is_signed && a_q[31]) ? -a_q : a_q;
    abs_b     = (is_signed && b_q[31]) ? -b_q : b_q;
    // Multiply: conditionally add the multiplicand to the upper half, then
    // shift the 65-bit {carry, acc, multiplier} right by one.
    mul_sum   = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
    mul_next  = {mul_sum, work[31:1]};
    // Divide: shift the next dividend bit into the partial remainder and
    // subtract the divisor only when it fits (restoring division).
    div_trial = work[63:31];
    div_ge    = div_trial >= {1'b0, opnd};
    div_diff  = div_trial - {1'b0, opnd};
    div_next  = div_ge ? {div_diff[31:0], work[30:0], 1'b1}
                       : {div_trial[31:0], work[30:0], 1'b0};
    prod_fix  = (sign_a ^ sign_b) ? -work : work;
    quot_fix  = (sign_a ^ sign_b) ? -work[31:0] : work[31:0];
    rem_fix   = sign_a ? -work[63:32] : work[63:32];
    hi_res    = prod_fix[63:32];
    lo_res    = prod_fix[31:0];
    if (is_div) begin
      if (b_q == 32'd0) begin
        hi_res = a_q;
        lo_res = 32'hFFFF_FFFF;
      end else begin
        hi_res = rem_fix;
        lo_res = quot_fix;
      end
    end
  end

  // Control state: FSM, iteration counter and architectural HI/LO.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      count <= 6'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (state == PREP) count <= 6'd0;
      else if (state == ITER) count <= count + 6'd1;
      if (state == FIX && !bus.FLUSH) begin
        hi_q <= hi_res;
        lo_q <= lo_res;
      end
    end
  end

  // Operand latch and iteration datapath.
  // NOTE: these registers are always written before being read in an operation, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_q <= bus.OP;
      a_q  <= bus.A;
      b_q  <= bus.B;
    end
    case (state)
      PREP: begin
        sign_a <= is_signed & a_q[31];
        sign_b <= is_signed & b_q[31];
        work   <= {32'd0, is_div ? abs_a : abs_b};
        opnd   <= is_div ? abs_b : abs_a;
      end
      ITER: work <= is_div ? div_next : mul_next;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer with a result scoreboard.
module tb_muldiv_sequencer;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic CLK;
  logic RESET;
  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  // Reference results computed with native wide arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t           r;
    longint         sa, sb, p, q, m;
    longint unsigned ua, ub, up, uq, um;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'd0, a};
    ub = {32'd0, b};
    r.name = "random";
    case (op)
      2'b00: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin up = ua * ub; r.hi = up[63:32]; r.lo = up[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
        else begin q = sa / sb; m = sa % sb; r.hi = m[31:0]; r.lo = q[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
        else begin uq = ua / ub; um = ua % ub; r.hi = um[31:0]; r.lo = uq[31:0]; end
      end
    endcase
    return r;
  endfunction

  task automatic push_exp(input string name, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    sb_q.push_back(e);
  endtask

  // Present one request; returns #1 after the edge that samples it (cycle N+1).
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    bus.START = 1'b1;
    bus.OP    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    bus.OP    = 2'($urandom);
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Follow one operation from cycle N+1 to its DONE pulse; optionally raise
  // HILO_READ or a new START at given cycles.
  task automatic wait_done(input int read_at, input int start_at, input bit start_pulse,
                           input logic [1:0] op2, input logic [31:0] a2, input logic [31:0] b2);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      if (cyc > 1) begin @(posedge CLK); #1; end
      checks++;
      if (bus.HILO_WE !== bus.DONE) begin
        errors++;
        $display("FAIL hilo_we_eq_done cyc N+%0d: hilo_we=%b done=%b, want equal", cyc, bus.HILO_WE, bus.DONE);
      end
      if (cyc <= 34) begin
        checks++;
        if (bus.BUSY !== 1'b1) begin
          errors++;
          $display("FAIL busy_high cyc N+%0d: got %b want 1", cyc, bus.BUSY);
        end
      end
      if (cyc == read_at) begin
        bus.HILO_READ = 1'b1;
        #1;
        checks++;
        if (bus.STALL !== 1'b1) begin
          errors++;
          $display("FAIL stall_on_read cyc N+%0d: got %b want 1", cyc, bus.STALL);
        end
        bus.HILO_READ = 1'b0;
      end
      if (cyc == start_at) begin
        bus.START = 1'b1;
        bus.OP    = op2;
        bus.A     = a2;
        bus.B     = b2;
        #1;
        checks++;
        if (bus.STALL !== 1'b1) begin
          errors++;
          $display("FAIL stall_on_start cyc N+%0d: got %b want 1", cyc, bus.STALL);
        end
      end
      if (start_pulse && cyc == start_at + 1) bus.START = 1'b0;
      if (bus.DONE === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (cyc != 35) begin
          errors++;
          $display("FAIL done_latency: got N+%0d want N+35", cyc);
        end
        checks++;
        if (bus.BUSY !== 1'b0) begin
          errors++;
          $display("FAIL busy_in_fin: got %b want 0", bus.BUSY);
        end
        bus.HILO_READ = 1'b1;
        #1;
        checks++;
        if (bus.STALL !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_fin: got %b want 0", bus.STALL);
        end
        bus.HILO_READ = 1'b0;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got DONE with empty scoreboard, want none");
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (bus.HI_OUT !== e.hi) begin
            errors++;
            $display("FAIL %s hi: got %h want %h", e.name, bus.HI_OUT, e.hi);
          end
          checks++;
          if (bus.LO_OUT !== e.lo) begin
            errors++;
            $display("FAIL %s lo: got %h want %h", e.name, bus.LO_OUT, e.lo);
          end
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no DONE within 40 cycles, want DONE at N+35");
    end
  endtask

  task automatic test_reset();
    RESET         = 1'b0;
    bus.START     = 1'b0;
    bus.OP        = 2'b00;
    bus.A         = 32'd0;
    bus.B         = 32'd0;
    bus.HILO_READ = 1'b0;
    bus.FLUSH     = 1'b0;
    #3;
    checks++;
    if ({bus.BUSY, bus.STALL, bus.DONE, bus.HILO_WE} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {bus.BUSY, bus.STALL, bus.DONE, bus.HILO_WE});
    end
    checks++;
    if ({bus.HI_OUT, bus.LO_OUT} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo: got %h want 0", {bus.HI_OUT, bus.LO_OUT});
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_multu();
    push_exp("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, 0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic test_mult_stall();
    push_exp("mult_neg3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(10, 0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic test_div();
    push_exp("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, 0, 1'b0, 2'b00, 32'd0, 32'd0);
    push_exp("divu_100_7", 32'd2, 32'd14);
    start_op(2'b11, 32'd100, 32'd7);
    wait_done(0, 0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic test_div_zero();
    push_exp("divu_by_zero", 32'h0000_0064, 32'hFFFF_FFFF);
    start_op(2'b11, 32'h0000_0064, 32'd0);
    wait_done(0, 0, 1'b0, 2'b00, 32'd0, 32'd0);
    push_exp("div_neg_by_zero", 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    start_op(2'b10, 32'hFFFF_FFFB, 32'd0);
    wait_done(0, 0, 1'b0, 2'b00, 32'd0, 32'd0);
    push_exp("div_overflow", 32'h0000_0000, 32'h8000_0000);
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, 0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  // A START pulse while busy stalls but must not be remembered.
  task automatic test_busy_start();
    bit extra;
    push_exp("multu_5x6", 32'd0, 32'd30);
    start_op(2'b01, 32'd5, 32'd6);
    wait_done(0, 5, 1'b1, 2'b01, 32'd9, 32'd9);
    extra = 1'b0;
    repeat (4) begin
      @(posedge CLK);
      #1;
      if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL start_not_queued: got activity after DONE, want idle");
    end
  endtask

  // START raised while busy and held through FIN is accepted there.
  task automatic test_back_to_back();
    push_exp("b2b_divu_1000_3", 32'd1, 32'd333);
    push_exp("b2b_multu", 32'h0000_0001, 32'h2345_6780);
    start_op(2'b11, 32'd1000, 32'd3);
    wait_done(0, 20, 1'b0, 2'b01, 32'h1234_5678, 32'h0000_0010);
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    checks++;
    if (bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_in_fin: busy got %b want 1", bus.BUSY);
    end
    wait_done(0, 0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic test_flush();
    bit bad;
    push_exp("multu_setup", 32'd1, 32'd2);
    start_op(2'b01, 32'h8000_0001, 32'd2);
    wait_done(0, 0, 1'b0, 2'b00, 32'd0, 32'd0);
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 2; c <= 10; c++) begin @(posedge CLK); #1; end
    bus.FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    bus.FLUSH = 1'b0;
    checks++;
    if (bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL flush_to_idle: busy got %b want 0", bus.BUSY);
    end
    bad = 1'b0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL flush_no_done: got activity after flush, want none");
    end
    checks++;
    if (bus.HI_OUT !== 32'd1 || bus.LO_OUT !== 32'd2) begin
      errors++;
      $display("FAIL flush_hilo_kept: got %h/%h want 00000001/00000002", bus.HI_OUT, bus.LO_OUT);
    end
    @(negedge CLK);
    bus.START = 1'b1;
    bus.FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    bus.FLUSH = 1'b0;
    checks++;
    if (bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL flush_beats_start: busy got %b want 0", bus.BUSY);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    start_op(2'b11, 32'd50, 32'd4);
    for (int c = 2; c <= 20; c++) begin @(posedge CLK); #1; end
    RESET         = 1'b0;
    bus.START     = 1'b1;
    bus.HILO_READ = 1'b1;
    bus.OP        = 2'b11;
    bus.A         = 32'd1000;
    bus.B         = 32'd3;
    #1;
    checks++;
    if ({bus.BUSY, bus.STALL, bus.DONE, bus.HILO_WE} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_flags: got %b want 0000", {bus.BUSY, bus.STALL, bus.DONE, bus.HILO_WE});
    end
    checks++;
    if ({bus.HI_OUT, bus.LO_OUT} !== 64'd0) begin
      errors++;
      $display("FAIL midreset_hilo: got %h want 0", {bus.HI_OUT, bus.LO_OUT});
    end
    bad = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midreset_no_accept: got activity in reset, want none");
    end
    bus.HILO_READ = 1'b0;
    push_exp("post_reset_divu", 32'd1, 32'd333);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    wait_done(0, 0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic test_random();
    exp_t        r;
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 2 == 1) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 2 == 1 && op[1] == 1'b1 && op[0] == 1'b0) b = -b;
      r = model(op, a, b);
      push_exp($sformatf("random%0d_op%0d", i, op), r.hi, r.lo);
      start_op(op, a, b);
      wait_done(0, 0, 1'b0, 2'b00, 32'd0, 32'd0);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_stall();
    test_div();
    test_div_zero();
    test_busy_start();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d pending want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: clock; all state changes on posedge.
REQ-002 SHALL have port RESET, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port START, input, 1 bit: request a new multiply or divide.
REQ-004 SHALL have port OP, input, 2 bits: operation; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports A and B, inputs, 32 bits each: operands; A is the multiplicand or dividend, B is the multiplier or divisor.
REQ-006 SHALL have port HILO_READ, input, 1 bit: EXE holds an MFHI or MFLO this cycle.
REQ-007 SHALL have port FLUSH, input, 1 bit: abort the operation in flight.
REQ-008 SHALL have port BUSY, output, 1 bit: operation in progress.
REQ-009 SHALL have port STALL, output, 1 bit: freeze the front-end/EXE pipeline this cycle.
REQ-010 SHALL have port DONE, output, 1 bit: one-cycle result-valid pulse.
REQ-011 SHALL have port HILO_WE, output, 1 bit: HI/LO architectural write strobe; always equal to DONE.
REQ-012 SHALL have ports HI_OUT and LO_OUT, outputs, 32 bits each: registered HI/LO values.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, ITER, FIX, FIN.
REQ-014 SHALL accept START only in IDLE or FIN; it latches OP, A and B and enters PREP. Operand changes after that are ignored.
REQ-015 In PREP, SHALL replace signed operands (OP 00/10) by their absolute values, record the result signs, clear the 6-bit iteration counter and enter ITER.
REQ-016 In ITER, SHALL perform one shift-add multiply step or one restoring-divide step per cycle.
REQ-017 SHALL leave ITER for FIX after exactly 32 ITER cycles; the counter increments per ITER cycle and exits at count 31.
REQ-018 In FIX, SHALL apply sign correction, load HI_OUT/LO_OUT and enter FIN.
REQ-019 SHALL use these sign rules:
- product: negate the 64-bit result when sign(A) XOR sign(B);
- quotient: negate when sign(A) XOR sign(B);
- remainder: takes the sign of A.
REQ-020 SHALL place results as follows:
- multiply: HI = product[63:32], LO = product[31:0];
- divide: HI = remainder, LO = quotient.
REQ-021 Divide by zero (B==0, OP 10/11) SHALL keep the full latency and produce HI = latched A, LO = 0xFFFFFFFF, for both DIV and DIVU.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL produce LO = 0x80000000, HI = 0.
REQ-023 Latency: START sampled at edge N SHALL give PREP at N+1, ITER at N+2..N+33, FIX at N+34, FIN at N+35.
REQ-024 SHALL hold DONE = HILO_WE = 1 only in FIN, for one cycle; FIN returns to IDLE unless START is accepted.
REQ-025 BUSY SHALL be 1 exactly in PREP, ITER and FIX.
REQ-026 STALL SHALL equal BUSY AND (START OR HILO_READ); it is combinational, with no added cycle.
REQ-027 START while BUSY SHALL be ignored and not queued; the requester holds START while STALL is 1.
REQ-028 FLUSH in any state SHALL force IDLE at the next edge:
- HI_OUT/LO_OUT unchanged;
- no DONE pulse;
- FLUSH and START in the same cycle: FLUSH wins and START is dropped.
REQ-029 HI_OUT/LO_OUT SHALL change only on the FIX-to-FIN edge, and SHALL hold their value in all other states.
REQ-030 All arithmetic SHALL be unsigned 64-bit internally; carries beyond 64 bits are discarded.

Reset
REQ-031 RESET low SHALL immediately force, regardless of CLK:
- state = IDLE, counter = 0;
- HI_OUT = LO_OUT = 0;
- BUSY = STALL = DONE = HILO_WE = 0.
REQ-032 Reset asserted mid-operation SHALL discard the operation with no DONE; after release the block accepts START in the first cycle.
REQ-033 SHALL display no result and accept no request while RESET is low.

Verification
REQ-034 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> DONE at N+35, HI=0xFFFFFFFE, LO=0x00000001, BUSY high N+1..N+34.
REQ-035 MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; a HILO_READ at N+10 gives STALL=1, and STALL=0 at N+35.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=100, B=7 -> LO=14, HI=2.
REQ-037 DIVU A=0x64, B=0 -> HI=0x64, LO=0xFFFFFFFF at N+35; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 Prior HI=1, LO=2; MULTU started, FLUSH at N+10 -> IDLE at N+11, no DONE, HI=1, LO=2; START during BUSY yields STALL=1 and is ignored.
REQ-039 RESET low at N+20 of DIVU -> all outputs 0 immediately, no DONE; START in the first cycle after release completes normally 35 cycles later.
